cache_line_addr_gen: RTL and testbench
======================================

CACHE_LINE_ADDR_GEN -- requirements
Module: cache_line_addr_gen

Interface
REQ-001 Parameter TAG_W, default 25, tag width (address bits [31:7]).
REQ-002 Parameter LINE_W, default 3, line index width (address bits [6:4]).
REQ-003 Parameter WORD_W, default 3, word-in-line width (address bits [3:1]); TAG_W+LINE_W+WORD_W+1 SHALL equal 32.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  line-transfer request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_tag  input  TAG_W  tag of line to transfer.
REQ-009 req_line_id  input  LINE_W  line index.
REQ-010 req_word_id  input  WORD_W  first (critical) word of burst.
REQ-011 req_write  input  1  1 = writeback, 0 = refill.
REQ-012 mem_addr_valid  output  1  beat address valid.
REQ-013 mem_addr_ready  input  1  memory accepts beat address.
REQ-014 mem_addr  output  32  byte address {tag, line_id, word_id, 1'b0}; bit 0 always 0.
REQ-015 mem_word_id  output  WORD_W  word index of current beat.
REQ-016 mem_write  output  1  captured req_write for current burst.
REQ-017 mem_last  output  1  current beat is final beat of burst.
REQ-018 done  output  1  one-cycle pulse: burst complete.

Function
REQ-019 States: IDLE, BURST; req_ready SHALL be 1 exactly in IDLE.
REQ-020 Request accepted on rising edge where req_valid && req_ready; tag, line_id, word_id, write captured; state -> BURST.
REQ-021 First beat SHALL present mem_addr_valid=1 in the cycle after acceptance (latency 1), with mem_word_id = captured req_word_id.
REQ-022 Beat completes on edge where mem_addr_valid && mem_addr_ready; mem_word_id then increments modulo 2^WORD_W (7 -> 0 wrap, critical-word-first).
REQ-023 While mem_addr_valid && !mem_addr_ready, mem_addr, mem_word_id, mem_write, mem_last SHALL hold stable.
REQ-024 Burst length SHALL be exactly 2^WORD_W (8) beats; beat counter 0..7; mem_last = 1 only on beat 7.
REQ-025 On completion of beat 7: state -> IDLE, mem_addr_valid -> 0, done = 1 for that following single cycle.
REQ-026 A request presented in the done cycle SHALL be accepted (req_ready=1 then); back-to-back bursts have one idle address cycle between them.
REQ-027 mem_addr tag and line bits SHALL be constant for the whole burst; only bits [3:1] change.
REQ-028 Request inputs SHALL be ignored while in BURST.
REQ-029 mem_addr_valid SHALL be 0 in IDLE; mem_addr, mem_word_id, mem_write, mem_last are don't-care but driven from registers (no X).

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, req_ready 1, mem_addr_valid 0, mem_last 0, done 0, mem_write 0, mem_addr 0, mem_word_id 0, beat counter 0.
REQ-031 Reset during BURST SHALL abandon the burst without a done pulse; first request after release behaves as from power-up.
REQ-032 Reset deassertion need not be synchronised in-block; accepted on first rising edge after release.

Structure
REQ-033 Shared package cache_pkg SHALL hold TAG_W/LINE_W/WORD_W defaults, WORDS_PER_LINE, the state enum, and an address-compose function (tag, line, word -> 32-bit address).
REQ-034 One sub-module is natural: cache_encode, combinational compose of {tag, line_id, word_id, 1'b0}, inverse of the existing address decoder; FSM/counter remain in top.

Verification
REQ-035 Refill tag=0x1ABCDE, line=5, word=0, mem_addr_ready=1 -> 8 beats 0x0D5E6F50..0x0D5E6F5E step 2, mem_last on 0x0D5E6F5E, done next cycle.
REQ-036 Critical word: tag=0, line=2, word=6 -> word order 6,7,0,1,2,3,4,5; addresses 0x2C,0x2E,0x20..0x2A; mem_last at word 5.
REQ-037 Backpressure: mem_addr_ready low 3 cycles on beat 2 -> mem_addr/mem_word_id stable, total burst 11 cycles, still 8 beats.
REQ-038 Back-to-back: req_valid held high, req_write=1 then 0 -> second request accepted in done cycle, mem_write toggles per burst.
REQ-039 Reset mid-burst after beat 3 -> mem_addr_valid 0 asynchronously, no done, req_ready 1; new request restarts at its word_id.
REQ-040 Request during BURST with different tag -> ignored, current burst addresses unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, burst state encoding and address composition for the line transfer path
package cache_pkg;
  localparam int DEF_TAG_W      = 25;
  localparam int DEF_LINE_W     = 3;
  localparam int DEF_WORD_W     = 3;
  localparam int WORDS_PER_LINE = 1 << DEF_WORD_W;
  typedef enum logic {S_IDLE, S_BURST} state_t;
  function automatic logic [31:0] compose_addr(
    input logic [DEF_TAG_W-1:0]  tag,
    input logic [DEF_LINE_W-1:0] line,
    input logic [DEF_WORD_W-1:0] word
  );
    return {tag, line, word, 1'b0};
  endfunction
endpackage

// File: rtl/cache_encode.sv
// cache_encode: packs tag/line/word into a halfword-aligned byte address (inverse of the address decoder)
module cache_encode import cache_pkg::*; #(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic [TAG_W-1:0]  tag,
  input  logic [LINE_W-1:0] line_id,
  input  logic [WORD_W-1:0] word_id,
  output logic [31:0]       addr
);
  assign addr = {tag, line_id, word_id, 1'b0};
endmodule

// File: rtl/cache_line_addr_gen.sv
// cache_line_addr_gen: emits one beat address per word of a cache line, critical word first,
// wrapping within the line, for refill and writeback bursts.
module cache_line_addr_gen import cache_pkg::*; #(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [LINE_W-1:0] req_line_id,
  input  logic [WORD_W-1:0] req_word_id,
  input  logic              req_write,
  output logic              mem_addr_valid,
  input  logic              mem_addr_ready,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_word_id,
  output logic              mem_write,
  output logic              mem_last,
  output logic              done
);
  localparam int WORDS = 1 << WORD_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS - 1);
  localparam logic [WORD_W-1:0] PRE_LAST  = WORD_W'(WORDS - 2);
  state_t              r_state;
  logic [TAG_W-1:0]    r_tag;
  logic [LINE_W-1:0]   r_line;
  logic [WORD_W-1:0]   r_word;
  logic [WORD_W-1:0]   r_beat;
  logic                r_write;
  logic                r_last;
  logic                r_done;
  logic [31:0]         w_addr;
  cache_encode #(.TAG_W(TAG_W), .LINE_W(LINE_W), .WORD_W(WORD_W)) u_enc (
    .tag(r_tag), .line_id(r_line), .word_id(r_word), .addr(w_addr)
  );
  assign req_ready      = r_state == S_IDLE;
  assign mem_addr_valid = r_state == S_BURST;
  assign mem_addr       = w_addr;
  assign mem_word_id    = r_word;
  assign mem_write      = r_write;
  assign mem_last       = r_last;
  assign done           = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tag   <= '0;
      r_line  <= '0;
      r_word  <= '0;
      r_beat  <= '0;
      r_write <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (req_valid) begin
          r_state <= S_BURST;
          r_tag   <= req_tag;
          r_line  <= req_line_id;
          r_word  <= req_word_id;
          r_write <= req_write;
          r_beat  <= '0;
          r_last  <= 1'b0;
        end
      end else if (mem_addr_ready) begin
        // word index wraps inside the line so the critical word goes out first
        r_word <= r_word + WORD_W'(1);
        r_beat <= r_beat + WORD_W'(1);
        r_last <= r_beat == PRE_LAST;
        if (r_beat == LAST_BEAT) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_last  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_line_addr_gen.sv
// tb_cache_line_addr_gen: directed vector table of full bursts plus hand-written
// backpressure, back-to-back and mid-burst reset sequences.
module tb_cache_line_addr_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [24:0] req_tag;
  logic [2:0]  req_line_id;
  logic [2:0]  req_word_id;
  logic        req_write;
  logic        mem_addr_valid;
  logic        mem_addr_ready;
  logic [31:0] mem_addr;
  logic [2:0]  mem_word_id;
  logic        mem_write;
  logic        mem_last;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [24:0] tag;
    logic [2:0]  line;
    logic [2:0]  word;
    logic        wr;
    logic [31:0] addr [8];
    logic [2:0]  wid  [8];
  } vec_t;
  vec_t vecs [3];

  cache_line_addr_gen dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_line_id(req_line_id), .req_word_id(req_word_id), .req_write(req_write),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
    .mem_addr(mem_addr), .mem_word_id(mem_word_id), .mem_write(mem_write),
    .mem_last(mem_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [24:0] t, input logic [2:0] l, input logic [2:0] w, input logic wr);
    req_valid = 1'b1; req_tag = t; req_line_id = l; req_word_id = w; req_write = wr;
  endtask

  logic [31:0] hold_addr;
  logic [2:0]  hold_word;
  int cyc, beats, stall;

  initial begin
    vecs[0].tag = 25'h1ABCDE; vecs[0].line = 3'd5; vecs[0].word = 3'd0; vecs[0].wr = 1'b0;
    vecs[0].addr = '{32'h0D5E6F50, 32'h0D5E6F52, 32'h0D5E6F54, 32'h0D5E6F56,
                     32'h0D5E6F58, 32'h0D5E6F5A, 32'h0D5E6F5C, 32'h0D5E6F5E};
    vecs[0].wid  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    vecs[1].tag = 25'h0; vecs[1].line = 3'd2; vecs[1].word = 3'd6; vecs[1].wr = 1'b0;
    vecs[1].addr = '{32'h2C, 32'h2E, 32'h20, 32'h22, 32'h24, 32'h26, 32'h28, 32'h2A};
    vecs[1].wid  = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    vecs[2].tag = 25'h1FFFFFF; vecs[2].line = 3'd7; vecs[2].word = 3'd7; vecs[2].wr = 1'b1;
    vecs[2].addr = '{32'hFFFFFFFE, 32'hFFFFFFF0, 32'hFFFFFFF2, 32'hFFFFFFF4,
                     32'hFFFFFFF6, 32'hFFFFFFF8, 32'hFFFFFFFA, 32'hFFFFFFFC};
    vecs[2].wid  = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

    rst_n = 1'b0; req_valid = 1'b0; req_tag = '0; req_line_id = '0; req_word_id = '0;
    req_write = 1'b0; mem_addr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(mem_addr_valid), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_word", 32'(mem_word_id), 32'd0);
    check("rst_last_done_write", {29'd0, mem_last, done, mem_write}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven full bursts with memory always ready
    for (int v = 0; v < 3; v++) begin
      drive_req(vecs[v].tag, vecs[v].line, vecs[v].word, vecs[v].wr);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        check($sformatf("v%0d_b%0d_valid", v, i), 32'(mem_addr_valid), 32'd1);
        check($sformatf("v%0d_b%0d_ready", v, i), 32'(req_ready), 32'd0);
        check($sformatf("v%0d_b%0d_addr", v, i), mem_addr, vecs[v].addr[i]);
        check($sformatf("v%0d_b%0d_word", v, i), 32'(mem_word_id), 32'(vecs[v].wid[i]));
        check($sformatf("v%0d_b%0d_write", v, i), 32'(mem_write), 32'(vecs[v].wr));
        check($sformatf("v%0d_b%0d_last", v, i), 32'(mem_last), 32'(i == 7));
        check($sformatf("v%0d_b%0d_done", v, i), 32'(done), 32'd0);
        @(negedge clk);
      end
      check($sformatf("v%0d_done", v), 32'(done), 32'd1);
      check($sformatf("v%0d_end_valid", v), 32'(mem_addr_valid), 32'd0);
      check($sformatf("v%0d_end_ready", v), 32'(req_ready), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), 32'(done), 32'd0);
    end

    // Backpressure: ready low for 3 cycles while beat 2 is presented
    drive_req(25'h123, 3'd1, 3'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0; beats = 0; stall = 0; hold_addr = '0; hold_word = '0;
    for (int k = 0; k < 30; k++) begin
      if (!mem_addr_valid) break;
      cyc++;
      if (beats == 2 && stall < 3) begin
        if (stall == 0) begin
          hold_addr = mem_addr; hold_word = mem_word_id;
          check("bp_beat2_addr", mem_addr, 32'h9194);
          check("bp_beat2_word", 32'(mem_word_id), 32'd2);
        end else begin
          check($sformatf("bp_stall%0d_addr", stall), mem_addr, hold_addr);
          check($sformatf("bp_stall%0d_word", stall), 32'(mem_word_id), 32'(hold_word));
          check($sformatf("bp_stall%0d_last", stall), 32'(mem_last), 32'd0);
        end
        mem_addr_ready = 1'b0;
        stall++;
      end else begin
        if (beats == 2) check("bp_release_addr", mem_addr, hold_addr);
        mem_addr_ready = 1'b1;
        beats++;
      end
      @(negedge clk);
    end
    mem_addr_ready = 1'b1;
    check("bp_cycles", 32'(cyc), 32'd11);
    check("bp_beats", 32'(beats), 32'd8);
    check("bp_done", 32'(done), 32'd1);
    @(negedge clk);

    // Back-to-back: req_valid held high; a changed tag during the burst is ignored
    drive_req(25'h00ABC, 3'd4, 3'd0, 1'b1);
    @(negedge clk);
    req_tag = 25'h1555555; req_line_id = 3'd1; req_word_id = 3'd3; req_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_first_b%0d_addr", i), mem_addr, 32'h00055E40 + 32'(2 * i));
      check($sformatf("b2b_first_b%0d_write", i), 32'(mem_write), 32'd1);
      @(negedge clk);
    end
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_ready_in_done", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_valid", 32'(mem_addr_valid), 32'd1);
    check("b2b_second_addr", mem_addr, 32'hAAAAAA96);
    check("b2b_second_write", 32'(mem_write), 32'd0);
    check("b2b_second_done_low", 32'(done), 32'd0);
    beats = 0;
    for (int k = 0; k < 20 && mem_addr_valid; k++) begin
      beats++;
      @(negedge clk);
    end
    check("b2b_second_beats", 32'(beats), 32'd8);
    check("b2b_second_done", 32'(done), 32'd1);
    @(negedge clk);

    // Reset mid-burst after beat 3 completes
    drive_req(25'h55, 3'd3, 3'd4, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rstm_pre_word", 32'(mem_word_id), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_valid_async", 32'(mem_addr_valid), 32'd0);
    check("rstm_ready_async", 32'(req_ready), 32'd1);
    check("rstm_addr_async", mem_addr, 32'd0);
    check("rstm_write_async", 32'(mem_write), 32'd0);
    @(negedge clk);
    check("rstm_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstm_no_done_after", 32'(done), 32'd0);
    drive_req(25'h1, 3'd0, 3'd3, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstm_new_valid", 32'(mem_addr_valid), 32'd1);
    check("rstm_new_addr", mem_addr, 32'h86);
    check("rstm_new_word", 32'(mem_word_id), 32'd3);
    check("rstm_new_last", 32'(mem_last), 32'd0);
    beats = 0;
    for (int k = 0; k < 20 && mem_addr_valid; k++) begin
      beats++;
      @(negedge clk);
    end
    check("rstm_new_beats", 32'(beats), 32'd8);
    check("rstm_new_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
